dram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 8192x32 data RAM between the CPU data port (port 0) and a secondary bus master such as a DMA or debug loader (port 1). It grants at most one access per cycle using round-robin priority, with an optional lock for back-to-back bursts and a bounded lock length so neither port starves. It sits between the requesters and the RAM macro, drives the macro's address, data, rnw and cs_b pins directly, and returns registered read data with a valid strobe.

---
 rtl/dram_arbiter_pkg.sv | 13 +
 rtl/dram_rr_pick.sv | 38 +++
 rtl/dram_arbiter.sv | 132 +++++++++++++
 tb/tb_dram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: owner state and port indices.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage

// File: rtl/dram_rr_pick.sv
// Combinational grant selector: a locked owner keeps the RAM until LOCK_MAX
// grants have passed with the other port waiting; otherwise round-robin.
module dram_rr_pick
  import dram_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  owner_e     owner,
  input  logic       last,
  input  logic [7:0] lock_cnt,
  output logic [1:0] gnt
);

  logic hold0;
  logic hold1;
  logic expire;

  assign hold0  = (owner == OWN_P0) && req[PORT0] && lock[PORT0];
  assign hold1  = (owner == OWN_P1) && req[PORT1] && lock[PORT1];
  assign expire = (lock_cnt == 8'(LOCK_MAX));

  always_comb begin
    gnt = 2'b00;
    if (hold0) begin
      gnt = (req[PORT1] && expire) ? 2'b10 : 2'b01;
    end else if (hold1) begin
      gnt = (req[PORT0] && expire) ? 2'b01 : 2'b10;
    end else if (req == 2'b11) begin
      // last = 1 means P1 was served most recently, so P0 wins the tie
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the single-port data RAM: drives the macro pins from
// the granted port and returns read data one cycle later with a valid strobe.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int AW       = 13,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [3:0]    i_wr0,
  input  logic [3:0]    i_wr1,
  input  logic [DW-1:0] i_din0,
  input  logic [DW-1:0] i_din1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_dout0,
  output logic [DW-1:0] o_dout1,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_din,
  output logic [3:0]    o_ram_wr,
  output logic          o_ram_rnw,
  output logic          o_ram_cs_b,
  input  logic [DW-1:0] i_ram_dout
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= 8'(LOCK_MAX)) ? 8'(LOCK_MAX) : v + 8'd1;
  endfunction

  owner_e        owner;
  logic          last;
  logic [7:0]    lock_cnt;
  logic [1:0]    rd_pend;
  logic [DW-1:0] dout0_p1;
  logic [DW-1:0] dout1_p1;
  logic [1:0]    req;
  logic [1:0]    lock;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          preempt;

  assign req  = {i_req1, i_req0};
  assign lock = {i_lock1, i_lock0};

  dram_rr_pick #(.LOCK_MAX(LOCK_MAX)) u_pick (
    .req      (req),
    .lock     (lock),
    .owner    (owner),
    .last     (last),
    .lock_cnt (lock_cnt),
    .gnt      (pick)
  );

  // No access may reach the RAM while reset is held.
  assign gnt    = pick & {2{i_rstb}};
  assign o_ack0 = gnt[PORT0];
  assign o_ack1 = gnt[PORT1];

  assign preempt = ((owner == OWN_P0) && req[PORT0] && lock[PORT0] && gnt[PORT1]) ||
                   ((owner == OWN_P1) && req[PORT1] && lock[PORT1] && gnt[PORT0]);

  // Stage p0: RAM pins straight from the granted port
  always_comb begin
    o_ram_addr = '0;
    o_ram_din  = '0;
    o_ram_wr   = 4'b0000;
    o_ram_rnw  = 1'b1;
    o_ram_cs_b = 1'b1;
    if (gnt[PORT0]) begin
      o_ram_addr = i_addr0;
      o_ram_din  = i_din0;
      o_ram_wr   = i_wr0;
      o_ram_rnw  = ~|i_wr0;
      o_ram_cs_b = 1'b0;
    end else if (gnt[PORT1]) begin
      o_ram_addr = i_addr1;
      o_ram_din  = i_din1;
      o_ram_wr   = i_wr1;
      o_ram_rnw  = ~|i_wr1;
      o_ram_cs_b = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      owner    <= OWN_NONE;
      last     <= 1'b1;
      lock_cnt <= 8'd0;
      rd_pend  <= 2'b00;
      dout0_p1 <= '0;
      dout1_p1 <= '0;
    end else begin
      rd_pend <= {gnt[PORT1] & ~|i_wr1, gnt[PORT0] & ~|i_wr0};
      if (rd_pend[PORT0]) dout0_p1 <= i_ram_dout;
      if (rd_pend[PORT1]) dout1_p1 <= i_ram_dout;
      if (|gnt) last <= gnt[PORT1];

      if (preempt) begin
        owner    <= OWN_NONE;
        lock_cnt <= 8'd0;
      end else if (gnt[PORT0]) begin
        owner    <= lock[PORT0] ? OWN_P0 : OWN_NONE;
        lock_cnt <= (lock[PORT0] && req[PORT1]) ?
                    ((owner == OWN_P0) ? sat_inc(lock_cnt) : 8'd1) : 8'd0;
      end else if (gnt[PORT1]) begin
        owner    <= lock[PORT1] ? OWN_P1 : OWN_NONE;
        lock_cnt <= (lock[PORT1] && req[PORT0]) ?
                    ((owner == OWN_P1) ? sat_inc(lock_cnt) : 8'd1) : 8'd0;
      end else begin
        owner    <= OWN_NONE;
        lock_cnt <= 8'd0;
      end
    end
  end

  // Stage p1: RAM data is live during the rvalid cycle, then held
  assign o_rvalid0 = rd_pend[PORT0];
  assign o_rvalid1 = rd_pend[PORT1];
  assign o_dout0   = rd_pend[PORT0] ? i_ram_dout : dout0_p1;
  assign o_dout1   = rd_pend[PORT1] ? i_ram_dout : dout1_p1;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 8192x32 byte-write RAM.
module tb_dram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rstb;
  logic          i_req0, i_req1, i_lock0, i_lock1;
  logic [AW-1:0] i_addr0, i_addr1;
  logic [3:0]    i_wr0, i_wr1;
  logic [DW-1:0] i_din0, i_din1;
  logic          o_ack0, o_ack1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_dout0, o_dout1;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic [3:0]    o_ram_wr;
  logic          o_ram_rnw, o_ram_cs_b;
  logic [DW-1:0] i_ram_dout;

  logic [DW-1:0] mem [0:8191];

  int n_cmp = 0;
  int n_bad = 0;

  dram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
    .i_clk(i_clk), .i_rstb(i_rstb),
    .i_req0(i_req0), .i_req1(i_req1), .i_lock0(i_lock0), .i_lock1(i_lock1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wr0(i_wr0), .i_wr1(i_wr1),
    .i_din0(i_din0), .i_din1(i_din1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_dout0(o_dout0), .o_dout1(o_dout1),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_wr(o_ram_wr),
    .o_ram_rnw(o_ram_rnw), .o_ram_cs_b(o_ram_cs_b), .i_ram_dout(i_ram_dout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (!o_ram_cs_b) begin
      if (o_ram_rnw) i_ram_dout <= mem[o_ram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (o_ram_wr[b]) mem[o_ram_addr][8*b +: 8] <= o_ram_din[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic       e1, a1;
  logic [7:0] p1n;
  int         w, maxw;

  initial begin
    i_rstb = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0; i_lock0 = 1'b0; i_lock1 = 1'b0;
    i_addr0 = '0; i_addr1 = '0; i_wr0 = 4'h0; i_wr1 = 4'h0;
    i_din0 = '0; i_din1 = '0;
    mem[13'h0010] <= 32'hDEADBEEF;
    mem[13'h0100] <= 32'hA0A00000;
    mem[13'h0200] <= 32'hB1B10001;
    mem[13'h1FFF] <= 32'h11223344;

    // reset state
    #2;
    chk("rst_ack0", 32'(o_ack0), 32'd0);
    chk("rst_ack1", 32'(o_ack1), 32'd0);
    chk("rst_cs_b", 32'(o_ram_cs_b), 32'd1);
    chk("rst_rnw", 32'(o_ram_rnw), 32'd1);
    chk("rst_wr", 32'(o_ram_wr), 32'd0);
    chk("rst_rvalid0", 32'(o_rvalid0), 32'd0);
    chk("rst_dout0", o_dout0, 32'd0);
    @(posedge i_clk);
    #2 i_rstb = 1'b1;
    tick();

    // single read on port 0
    i_req0 = 1'b1; i_addr0 = 13'h0010; i_wr0 = 4'h0;
    #1;
    chk("rd_ack0", 32'(o_ack0), 32'd1);
    chk("rd_cs_b", 32'(o_ram_cs_b), 32'd0);
    chk("rd_rnw", 32'(o_ram_rnw), 32'd1);
    chk("rd_addr", 32'(o_ram_addr), 32'h10);
    tick();
    i_req0 = 1'b0;
    #1;
    chk("rd_rvalid0", 32'(o_rvalid0), 32'd1);
    chk("rd_dout0", o_dout0, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(o_rvalid1), 32'd0);
    chk("rd_cs_b_idle", 32'(o_ram_cs_b), 32'd1);
    tick();
    chk("rd_rvalid0_off", 32'(o_rvalid0), 32'd0);
    chk("rd_dout0_held", o_dout0, 32'hDEADBEEF);

    // both ports reading continuously: last was P0, so P1 leads
    i_req0 = 1'b1; i_addr0 = 13'h0100;
    i_req1 = 1'b1; i_addr1 = 13'h0200;
    for (int k = 0; k < 8; k++) begin
      #1;
      e1 = (k % 2 == 0);
      chk($sformatf("alt_ack1_k%0d", k), 32'(o_ack1), 32'(e1));
      chk($sformatf("alt_ack0_k%0d", k), 32'(o_ack0), 32'(!e1));
      if (k > 0) begin
        chk($sformatf("alt_rvalid1_k%0d", k), 32'(o_rvalid1), 32'(!e1));
        chk($sformatf("alt_rvalid0_k%0d", k), 32'(o_rvalid0), 32'(e1));
        if (e1) chk($sformatf("alt_dout0_k%0d", k), o_dout0, 32'hA0A00000);
        else    chk($sformatf("alt_dout1_k%0d", k), o_dout1, 32'hB1B10001);
      end
      tick();
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    #1;
    chk("alt_tail_rvalid0", 32'(o_rvalid0), 32'd1);
    chk("alt_tail_rvalid1", 32'(o_rvalid1), 32'd0);
    chk("alt_tail_dout0", o_dout0, 32'hA0A00000);
    tick();

    // byte-lane write then read back
    i_req0 = 1'b1; i_addr0 = 13'h1FFF; i_wr0 = 4'b0100; i_din0 = 32'h00AB0000;
    #1;
    chk("bw_ack0", 32'(o_ack0), 32'd1);
    chk("bw_rnw", 32'(o_ram_rnw), 32'd0);
    chk("bw_ram_wr", 32'(o_ram_wr), 32'h4);
    tick();
    i_wr0 = 4'b0000;
    #1;
    chk("bw_no_rvalid", 32'(o_rvalid0), 32'd0);
    chk("bw_rd_ack0", 32'(o_ack0), 32'd1);
    tick();
    i_req0 = 1'b0;
    #1;
    chk("bw_rd_dout0", o_dout0, 32'h11AB3344);
    tick();

    // P1 locked burst of 20 writes against a held P0 request
    p1n = 8'd0; w = 0; maxw = 0;
    i_req0 = 1'b1; i_addr0 = 13'h0300; i_wr0 = 4'hF; i_din0 = 32'h5A5A5A5A;
    i_req1 = 1'b1; i_lock1 = 1'b1; i_addr1 = 13'h0400; i_wr1 = 4'hF; i_din1 = 32'hC0000000;
    for (int c = 0; c < 22; c++) begin
      #1;
      e1 = !(c == 8 || c == 17);
      chk($sformatf("burst_ack1_c%0d", c), 32'(o_ack1), 32'(e1));
      chk($sformatf("burst_ack0_c%0d", c), 32'(o_ack0), 32'(!e1));
      if (o_ack1) begin
        w++;
        if (w > maxw) maxw = w;
      end else w = 0;
      a1 = o_ack1;
      tick();
      if (a1) begin
        p1n++;
        i_addr1 = 13'h0400 + 13'(p1n);
        i_din1  = 32'hC0000000 | 32'(p1n);
        if (p1n == 8'd20) begin
          i_req1 = 1'b0; i_lock1 = 1'b0;
        end
      end
    end
    #1;
    chk("burst_tail_ack0", 32'(o_ack0), 32'd1);
    chk("burst_tail_ack1", 32'(o_ack1), 32'd0);
    chk("burst_p0_wait", 32'(maxw), 32'd8);
    tick();
    i_req0 = 1'b0; i_wr0 = 4'h0;
    tick();
    chk("burst_last_word", mem[13'h0413], 32'hC0000013);
    chk("burst_first_word", mem[13'h0400], 32'hC0000000);

    // locked P0 drops req while P1 waits
    i_req0 = 1'b1; i_lock0 = 1'b1; i_addr0 = 13'h0100;
    #1;
    chk("ld_a_ack0", 32'(o_ack0), 32'd1);
    tick();
    i_req1 = 1'b1; i_addr1 = 13'h0200; i_wr1 = 4'h0;
    #1;
    chk("ld_b_ack0", 32'(o_ack0), 32'd1);
    chk("ld_b_ack1", 32'(o_ack1), 32'd0);
    tick();
    #1;
    chk("ld_c_ack0", 32'(o_ack0), 32'd1);
    chk("ld_c_ack1", 32'(o_ack1), 32'd0);
    tick();
    i_req0 = 1'b0; i_lock0 = 1'b0;
    #1;
    chk("ld_d_ack1", 32'(o_ack1), 32'd1);
    chk("ld_d_ack0", 32'(o_ack0), 32'd0);
    chk("ld_d_dout0", o_dout0, 32'hA0A00000);
    tick();
    i_req1 = 1'b0;
    i_req0 = 1'b1; i_addr0 = 13'h0010;
    #1;
    chk("ld_e_ack0", 32'(o_ack0), 32'd1);
    chk("ld_e_rvalid1", 32'(o_rvalid1), 32'd1);
    chk("ld_e_dout1", o_dout1, 32'hB1B10001);
    tick();

    // reset pulse after a read ack drops the pending rvalid
    i_addr0 = 13'h0100;
    #1;
    chk("rp_ack0", 32'(o_ack0), 32'd1);
    chk("rp_prev_dout0", o_dout0, 32'hDEADBEEF);
    #1 i_rstb = 1'b0;
    #1;
    chk("rp_ack0_in_rst", 32'(o_ack0), 32'd0);
    chk("rp_cs_b_in_rst", 32'(o_ram_cs_b), 32'd1);
    chk("rp_dout0_in_rst", o_dout0, 32'd0);
    i_req0 = 1'b0;
    tick();
    chk("rp_no_rvalid0", 32'(o_rvalid0), 32'd0);
    chk("rp_rnw", 32'(o_ram_rnw), 32'd1);
    chk("rp_wr", 32'(o_ram_wr), 32'd0);
    #1 i_rstb = 1'b1;
    #1;
    i_req0 = 1'b1; i_addr0 = 13'h0100;
    i_req1 = 1'b1; i_addr1 = 13'h0200;
    #1;
    chk("rp_tie_ack0", 32'(o_ack0), 32'd1);
    chk("rp_tie_ack1", 32'(o_ack1), 32'd0);
    tick();
    i_req0 = 1'b0; i_req1 = 1'b0;
    #1;
    chk("rp_tie_rvalid0", 32'(o_rvalid0), 32'd1);
    chk("rp_tie_dout0", o_dout0, 32'hA0A00000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
